// File: rtl/led_run_decoder.sv
// rtl/led_run_decoder.sv - one-hot LED bar driver with prescaled static/up/down/bounce sequencer
// Position and one-hot drive are computed together and registered on the same edge.
module led_run_decoder #(
   parameter int SEL_W = 3,
   parameter int DIV_W = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [DIV_W-1:0]      div,
   output logic [(1<<SEL_W)-1:0] y,
   output logic [SEL_W-1:0]      pos,
   output logic                  tick,
   output logic                  wrap
);

   localparam int N = 1 << SEL_W;
   localparam logic [SEL_W-1:0] POS_MAX = {SEL_W{1'b1}};

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_UP     = 2'b01,
      MODE_DOWN   = 2'b10,
      MODE_BOUNCE = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   logic [DIV_W-1:0] cnt, cnt_n;
   logic [SEL_W-1:0] pos_n;
   logic [N-1:0]     y_n;
   logic             tick_n, wrap_n;
   dir_e             dir, dir_n;
   mode_e            mode_q, mode_q_n;
   mode_e            mode_in;

   assign mode_in = mode_e'(mode);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         pos    <= '0;
         dir    <= DIR_UP;
         mode_q <= MODE_STATIC;
         tick   <= 1'b0;
         wrap   <= 1'b0;
         y      <= '0;
      end else begin
         cnt    <= cnt_n;
         pos    <= pos_n;
         dir    <= dir_n;
         mode_q <= mode_q_n;
         tick   <= tick_n;
         wrap   <= wrap_n;
         y      <= y_n;
      end
   end

   always_comb begin
      cnt_n    = cnt;
      pos_n    = pos;
      dir_n    = dir;
      mode_q_n = mode_q;
      tick_n   = 1'b0;
      wrap_n   = 1'b0;
      y_n      = '0;

      if (en) begin
         mode_q_n = mode_in;
         // A mode change restarts the prescaler and suppresses this cycle's step.
         if (mode_in != mode_q) begin
            cnt_n = '0;
            dir_n = DIR_UP;
         end else begin
            // >= rather than == so a lowered div never forces a long counter wrap.
            if (cnt >= div) begin
               tick_n = 1'b1;
               cnt_n  = '0;
            end else begin
               cnt_n = cnt + DIV_W'(1);
            end

            case (mode_q)
               MODE_STATIC: pos_n = sel;
               MODE_UP: begin
                  if (tick_n) begin
                     pos_n  = pos + SEL_W'(1);
                     wrap_n = (pos == POS_MAX);
                  end
               end
               MODE_DOWN: begin
                  if (tick_n) begin
                     pos_n  = pos - SEL_W'(1);
                     wrap_n = (pos == '0);
                  end
               end
               MODE_BOUNCE: begin
                  if (tick_n) begin
                     // Turn around immediately so each end LED is lit for one step only.
                     if (dir == DIR_UP) begin
                        if (pos == POS_MAX) begin
                           dir_n  = DIR_DOWN;
                           pos_n  = pos - SEL_W'(1);
                           wrap_n = 1'b1;
                        end else begin
                           pos_n = pos + SEL_W'(1);
                        end
                     end else begin
                        if (pos == '0) begin
                           dir_n  = DIR_UP;
                           pos_n  = pos + SEL_W'(1);
                           wrap_n = 1'b1;
                        end else begin
                           pos_n = pos - SEL_W'(1);
                        end
                     end
                  end
               end
               default: pos_n = pos;
            endcase
         end

         y_n = N'(1) << pos_n;
      end
   end

endmodule

// File: tb/tb_led_run_decoder.sv
// tb/tb_led_run_decoder.sv - directed-vector bench for led_run_decoder
module tb_led_run_decoder;

   localparam int SEL_W = 3;
   localparam int DIV_W = 24;
   localparam int N     = 1 << SEL_W;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [1:0]       mode;
   logic [SEL_W-1:0] sel;
   logic [DIV_W-1:0] div;
   logic [N-1:0]     y;
   logic [SEL_W-1:0] pos;
   logic             tick;
   logic             wrap;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   led_run_decoder #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode),
      .sel  (sel),
      .div  (div),
      .y    (y),
      .pos  (pos),
      .tick (tick),
      .wrap (wrap)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input int p, input logic t, input logic w, input logic lit);
      @(posedge clk);
      #1;
      chk({tag, ".pos"},  32'(pos),  32'(p));
      chk({tag, ".tick"}, 32'(tick), 32'(t));
      chk({tag, ".wrap"}, 32'(wrap), 32'(w));
      chk({tag, ".y"},    32'(y),    lit ? (32'd1 << p) : 32'd0);
   endtask

   int bseq [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

   initial begin
      rst  = 1'b1;
      en   = 1'b1;
      mode = 2'b01;
      sel  = '0;
      div  = '0;

      step("rst0", 0, 0, 0, 0);
      step("rst1", 0, 0, 0, 0);
      rst = 1'b0;
      step("rel", 0, 0, 0, 1);

      mode = 2'b00;
      step("st_mc", 0, 0, 0, 1);
      for (int i = 0; i < N; i++) begin
         sel = SEL_W'(i);
         step($sformatf("st%0d", i), i, 1, 0, 1);
      end
      en = 1'b0;
      step("blank", 7, 0, 0, 0);
      en  = 1'b1;
      sel = '0;
      step("st_back", 0, 1, 0, 1);

      div  = DIV_W'(3);
      mode = 2'b01;
      step("up_mc", 0, 0, 0, 1);
      for (int s = 1; s <= N; s++) begin
         for (int k = 0; k < 3; k++)
            step($sformatf("up_wait%0d", s), (s - 1) % N, 0, 0, 1);
         step($sformatf("up_tick%0d", s), s % N, 1, (s == N), 1);
      end

      div  = '0;
      mode = 2'b11;
      step("bn_mc", 0, 0, 0, 1);
      for (int i = 0; i < 15; i++)
         step($sformatf("bn%0d", i), bseq[i], 1, (i == 7 || i == 14), 1);
      step("bn_x", 2, 1, 0, 1);

      mode = 2'b10;
      step("dn_mc", 2, 0, 0, 1);
      step("dn1", 1, 1, 0, 1);
      step("dn0", 0, 1, 0, 1);
      step("dn7", 7, 1, 1, 1);
      mode = 2'b01;
      step("sw_mc", 7, 0, 0, 1);
      step("sw0", 0, 1, 1, 1);
      step("sw1", 1, 1, 0, 1);

      div = DIV_W'(10);
      for (int k = 0; k < 8; k++)
         step($sformatf("d10_%0d", k), 1, 0, 0, 1);
      div = DIV_W'(2);
      step("d2_t", 2, 1, 0, 1);
      step("d2_a", 2, 0, 0, 1);
      step("d2_b", 2, 0, 0, 1);
      step("d2_t2", 3, 1, 0, 1);

      step("pre_en", 3, 0, 0, 1);
      en = 1'b0;
      for (int k = 0; k < 5; k++)
         step($sformatf("off%0d", k), 3, 0, 0, 0);
      en = 1'b1;
      step("res_a", 3, 0, 0, 1);
      step("res_t", 4, 1, 0, 1);

      mode = 2'b11;
      div  = '0;
      step("rb_mc", 4, 0, 0, 1);
      step("rb5", 5, 1, 0, 1);
      step("rb6", 6, 1, 0, 1);
      step("rb7", 7, 1, 0, 1);
      step("rb6d", 6, 1, 1, 1);
      rst = 1'b1;
      step("rb_rst", 0, 0, 0, 0);
      rst = 1'b0;
      step("rb_mc2", 0, 0, 0, 1);
      step("rb1", 1, 1, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/led_run_decoder.md
Name: led_run_decoder

Overview:
- Parametrised successor of the board's 3-to-8 LED decoder: SEL_W-bit position -> 2^SEL_W one-hot LED drive, outputs registered.
- Adds a prescaled sequencer: static select, running light up, running light down, ping-pong bounce.
- Sits between the board switches/buttons and the LED bank; one instance per LED bar.

Parameters:
- SEL_W, 3, position width; LED count N = 2^SEL_W (SEL_W >= 1).
- DIV_W, 24, prescaler width; step period = div+1 clocks.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  output enable; low blanks LEDs and freezes the sequence.
- mode  in  2  00 STATIC, 01 UP, 10 DOWN, 11 BOUNCE.
- sel  in  SEL_W  position used in STATIC mode.
- div  in  DIV_W  prescaler terminal count.
- y  out  N  one-hot LED drive; bit k high when pos==k and en.
- pos  out  SEL_W  current position.
- tick  out  1  one-cycle pulse on each prescaler step.
- wrap  out  1  one-cycle pulse when the sequence turns at an end.

Behaviour:
- Reset: y=0, pos=0, tick=0, wrap=0, prescaler cnt=0, bounce dir=up, mode_q=00. Reset wins over all other inputs.
- All outputs are registered. y is always onehot(pos) when en was high at the last edge, and 0 otherwise. y and pos update on the same edge; there is no skew between them.
- Prescaler, only while en=1:
  - If cnt >= div: tick<=1 and cnt<=0.
  - Else: cnt<=cnt+1 and tick<=0.
  - div=0 gives a tick every cycle.
  - Lowering div mid-count below cnt fires the tick on the next edge; no long wrap of the counter.
- en=0: cnt held at its value, pos held, tick=0, wrap=0, y=0. Re-enabling resumes from the held cnt and pos.
- Mode change, detected as mode != mode_q while en=1: cnt<=0, tick=0, dir<=up, pos retained. mode_q updates every enabled cycle.
- STATIC: pos<=sel every enabled cycle, so 1-cycle latency sel->y. The prescaler still runs and tick still pulses. wrap=0.
- UP, on tick:
  - pos<=pos+1, wrapping modulo N.
  - wrap=1 on the tick where pos goes N-1 -> 0.
- DOWN, on tick:
  - pos<=pos-1, wrapping modulo N.
  - wrap=1 on the tick where pos goes 0 -> N-1.
- BOUNCE, on tick:
  - dir=up and pos<N-1: pos+1.
  - dir=up and pos==N-1: dir<=down, pos<=N-2, wrap=1.
  - dir=down and pos>0: pos-1.
  - dir=down and pos==0: dir<=up, pos<=1, wrap=1.
  - There is no dwell at the ends; the end LED is lit for exactly one step.
  - N=2 (SEL_W=1) alternates 0,1,0,1 with wrap on every tick.
- Non-tick cycles: pos unchanged and wrap=0. wrap is only ever high in a cycle where tick is high.
- Mode change and tick in the same cycle: the mode change wins; no step that cycle.
- Output invariant: y is one-hot or zero at every edge; never more than one bit set.

Test Plan:
- Reset/blank: assert rst 2 cycles with en=1, mode=UP. Then y=0, pos=0, tick=0. On the first enabled edge after reset release, y=8'h01.
- STATIC decode: mode=00, sweep sel 0..7 with en=1. Each y = 1<<sel one cycle later (8'h01..8'h80). Drop en: y=8'h00 next cycle with pos held.
- UP with prescale: div=3, mode=01 from pos=0.
  - tick every 4th cycle.
  - pos 1,2,...,7,0.
  - wrap high only on the 7->0 tick.
  - y=8'h80 then 8'h01.
- BOUNCE ends: div=0, mode=11 from pos=0.
  - pos sequence 1..7,6,...,0,1.
  - wrap on the ticks entering 6 and entering 1.
  - Never two consecutive 7s or 0s.
- DOWN and mode switch: div=0, mode=10 from pos=2 gives pos 1,0,7 with wrap on 0->7. Switch to UP mid-run: no step in the switch cycle, cnt cleared, then pos increments from the held value.
- Boundary timing:
  - div=10 with cnt at 8, set div=2: tick on the next edge, then every 3 cycles.
  - en low for 5 cycles mid-count: no tick; cnt resumes from the held value.
  - rst asserted mid-BOUNCE with dir=down: pos=0, dir=up on the next edge.
